gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter data_width, default 8, the counter width in bits (minimum 2).
REQ-002 SHALL have parameter wrap_en, default 1: 1 means wrap at the range ends; 0 means saturate at the range ends.
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous clear to zero.
REQ-006 SHALL have port load  input  1  synchronous load of load_val.
REQ-007 SHALL have port load_val  input  data_width  binary value to load.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port up_dn  input  1  direction: 1 means increment, 0 means decrement.
REQ-010 SHALL have port bin_out  output  data_width  registered binary count.
REQ-011 SHALL have port gray_out  output  data_width  registered Gray code of bin_out; this port feeds the downstream graycode_converter.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on wrap-around.
REQ-013 SHALL have port sat  output  1  level signal, high while the count is held at a range end (wrap_en=0 only).
REQ-014 SHALL have port changed  output  1  one-cycle pulse on any change of count value.

Function
REQ-015 Per-cycle priority SHALL be: clr, then load, then en, then hold.
REQ-016 clr=1 SHALL set bin_out=0 and gray_out=0 at the next edge; en and load are ignored in that cycle.
REQ-017 load=1 (clr=0) SHALL set bin_out=load_val and gray_out=load_val^(load_val>>1) at the next edge.
REQ-018 en=1 with up_dn=1 SHALL set bin_out=bin_out+1, modulo 2^data_width.
REQ-019 en=1 with up_dn=0 SHALL set bin_out=bin_out-1, modulo 2^data_width.
REQ-020 gray_out SHALL be registered from the next binary value: zero added latency relative to bin_out, and the two outputs always consistent in the same cycle.
REQ-021 On any en step, exactly one bit of gray_out SHALL change.
REQ-022 wrap_en=1: the transition up from all-ones to 0, or down from 0 to all-ones, SHALL pulse wrap for exactly the cycle after the edge.
REQ-023 wrap_en=0: an up step at all-ones, or a down step at 0, SHALL leave the count unchanged and produce no wrap pulse.
REQ-024 sat SHALL be high whenever wrap_en=0 and the count sits at the end matching the current up_dn (all-ones with up, zero with down); it SHALL be combinational from registered state and up_dn.
REQ-025 wrap_en=1: sat SHALL be constant 0.
REQ-026 wrap SHALL be registered and SHALL never assert as a result of clr or load, even when those change the value across a range boundary.
REQ-027 changed SHALL be registered and high for one cycle after any edge at which bin_out took a different value, whether by clr, load or count.
REQ-028 A load of the current value, or a clr while already at 0, SHALL leave changed low.
REQ-029 en held high continuously SHALL advance the count once per cycle with no bubbles.

Reset
REQ-030 rst_n low SHALL immediately force bin_out=0, gray_out=0, wrap=0 and changed=0, independent of clk.
REQ-031 sat SHALL follow its definition during reset (1 if wrap_en=0 and up_dn=0).
REQ-032 Reset asserted mid-count SHALL discard all state; counting SHALL resume from 0 on the first rising edge after rst_n deasserts.
REQ-033 rst_n SHALL be the only asynchronous input; clr is synchronous only.

Structure
REQ-034 A shared package graycode_pkg SHALL hold the bin2gray and gray2bin functions, parameterised by width, for use by this block, graycode_converter and the benches.
REQ-035 The default data_width value SHALL be a single constant shared with graycode_converter.
REQ-036 The block SHALL have no sub-module: one register process for the count and flags, with combinational next-state logic.
REQ-037 The downstream graycode_converter SHALL not be instantiated inside gray_counter.

Verification
REQ-038 Reset, then en=1, up_dn=1, data_width=8, wrap_en=1 for 260 cycles -> gray_out sequence 0,1,3,2,6,...; wrap pulses once at the 255->0 step; exactly one gray bit toggles per step.
REQ-039 load_val=8'h80 with load=1, then en=1 and up_dn=0 for 2 cycles -> bin_out 128, 127, 126; gray_out 8'hC0, 8'h40, 8'h41.
REQ-040 wrap_en=0, load 8'hFE, en=1, up_dn=1 for 4 cycles -> bin_out 254, 255, 255, 255; sat=1 from 255 onward; wrap never pulses; changed pulses twice.
REQ-041 clr=1, load=1 and en=1 in the same cycle at count 37 -> bin_out=0, changed=1, wrap=0.
REQ-042 rst_n pulsed low asynchronously mid-cycle at count 100 -> outputs are 0 before the next edge; counting restarts 0, 1, 2.
REQ-043 gray_out connected to graycode_converter configured for gray-to-binary, with a 300-cycle random mix of clr/load/en/up_dn -> converter dout equals bin_out every cycle.

Source files
------------

// File: rtl/graycode_pkg.sv
// Shared Gray-code helpers and constants for gray_counter, graycode_converter
// and their benches.
package graycode_pkg;

  // Default counter width, shared with graycode_converter.
  localparam int unsigned GRAY_DATA_WIDTH = 8;

  // Widest word the helper functions handle; callers zero-extend/truncate.
  localparam int unsigned GRAY_MAX_WIDTH = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Per-cycle action chosen by the counter, highest priority last.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } count_op_e;

  // Keeps only the low 'width' bits; width=64 wraps the shift to an all-ones mask.
  function automatic gray_word_t width_mask(input int unsigned width);
    return (gray_word_t'(1) << width) - gray_word_t'(1);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b, input int unsigned width);
    gray_word_t w_b;
    w_b = b & width_mask(width);
    return w_b ^ (w_b >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic gray_word_t gray2bin(input gray_word_t g, input int unsigned width);
    gray_word_t w_g;
    gray_word_t w_b;
    w_g = g & width_mask(width);
    w_b = '0;
    for (int unsigned i = 0; i < GRAY_MAX_WIDTH; i++) begin
      if (i < width) begin
        w_b = w_b ^ (w_g >> i);
      end
    end
    return w_b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output, wrap or
// saturate behaviour at the range ends, and wrap/sat/changed status flags.
module gray_counter
  import graycode_pkg::*;
#(
  parameter int unsigned data_width = GRAY_DATA_WIDTH,
  parameter int unsigned wrap_en    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [data_width-1:0] load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [data_width-1:0] bin_out,
  output logic [data_width-1:0] gray_out,
  output logic                  wrap,
  output logic                  sat,
  output logic                  changed
);

  logic [data_width-1:0] r_bin;
  logic [data_width-1:0] r_gray;
  logic                  r_wrap;
  logic                  r_changed;

  count_op_e             w_op;
  logic [data_width-1:0] w_bin_next;
  logic [data_width-1:0] w_gray_next;
  logic                  w_wrap_next;
  logic                  w_changed_next;
  logic                  w_at_max;
  logic                  w_at_min;

  assign w_at_max = (r_bin == '1);
  assign w_at_min = (r_bin == '0);

  // Priority select of this cycle's action: clr, load, en, hold.
  always_comb begin
    w_op = OP_HOLD;
    if (clr) begin
      w_op = OP_CLR;
    end else if (load) begin
      w_op = OP_LOAD;
    end else if (en) begin
      w_op = OP_STEP;
    end
  end

  // Next binary value and flags; wrap only ever comes from a count step.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    unique case (w_op)
      OP_CLR:  w_bin_next = '0;
      OP_LOAD: w_bin_next = load_val;
      OP_STEP: begin
        if (up_dn) begin
          if (w_at_max) begin
            if (wrap_en != 0) begin
              w_bin_next  = '0;
              w_wrap_next = 1'b1;
            end
          end else begin
            w_bin_next = r_bin + data_width'(1);
          end
        end else begin
          if (w_at_min) begin
            if (wrap_en != 0) begin
              w_bin_next  = '1;
              w_wrap_next = 1'b1;
            end
          end else begin
            w_bin_next = r_bin - data_width'(1);
          end
        end
      end
      default: w_bin_next = r_bin;
    endcase
    w_changed_next = (w_bin_next != r_bin);
    w_gray_next    = data_width'(bin2gray(gray_word_t'(w_bin_next), data_width));
  end

  // Count, Gray shadow and pulse flags share one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_gray    <= '0;
      r_wrap    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_bin     <= w_bin_next;
      r_gray    <= w_gray_next;
      r_wrap    <= w_wrap_next;
      r_changed <= w_changed_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign changed  = r_changed;
  assign sat      = (wrap_en == 0) && (up_dn ? w_at_max : w_at_min);

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: one wrapping and one saturating instance share
// stimulus and are checked against an integer-arithmetic reference model.
module tb_gray_counter;
  import graycode_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;

  logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
  logic         wrap_w, sat_w, chg_w, wrap_s, sat_s, chg_s;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: count values and expected pulse flags for each instance
  int m_w = 0, m_s = 0;
  bit e_wrap_w = 0, e_chg_w = 0, e_wrap_s = 0, e_chg_s = 0;

  always #5 clk = ~clk;

  gray_counter #(.data_width(W), .wrap_en(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .bin_out(bin_w), .gray_out(gray_w),
    .wrap(wrap_w), .sat(sat_w), .changed(chg_w));

  gray_counter #(.data_width(W), .wrap_en(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .bin_out(bin_s), .gray_out(gray_s),
    .wrap(wrap_s), .sat(sat_s), .changed(chg_s));

  function automatic void nxt(input int cur, input bit wrap_mode, output int nv, output bit wr);
    nv = cur;
    wr = 0;
    if (clr) nv = 0;
    else if (load) nv = int'(load_val);
    else if (en) begin
      if (up_dn) begin
        if (cur == MAXV) begin
          if (wrap_mode) begin nv = 0; wr = 1; end
        end else nv = cur + 1;
      end else begin
        if (cur == 0) begin
          if (wrap_mode) begin nv = MAXV; wr = 1; end
        end else nv = cur - 1;
      end
    end
  endfunction

  function automatic logic [W-1:0] ref_gray(input int v);
    return W'(v ^ (v >> 1));
  endfunction

  // One clock edge; model advances from the inputs held across that edge.
  task automatic tick();
    int nw, ns;
    bit ww, ws;
    nxt(m_w, 1'b1, nw, ww);
    nxt(m_s, 1'b0, ns, ws);
    @(posedge clk);
    #1;
    e_chg_w = (nw != m_w); e_wrap_w = ww; m_w = nw;
    e_chg_s = (ns != m_s); e_wrap_s = ws; m_s = ns;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bin_w !== '0 || gray_w !== '0 || wrap_w !== 1'b0 || chg_w !== 1'b0 || sat_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrap: bin=%h gray=%h wrap=%b chg=%b sat=%b, want all 0", bin_w, gray_w, wrap_w, chg_w, sat_w);
    end
    n_tests++;
    if (bin_s !== '0 || gray_s !== '0 || wrap_s !== 1'b0 || chg_s !== 1'b0 || sat_s !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sat: bin=%h gray=%h wrap=%b chg=%b sat=%b, want 0 0 0 0 sat=1", bin_s, gray_s, wrap_s, chg_s, sat_s);
    end
    #10 rst_n = 1'b1;
    m_w = 0; m_s = 0;
  endtask

  task automatic test_count_up();
    logic [W-1:0] prev;
    int wraps = 0;
    int bad_seq = 0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 260; i++) begin
      prev = gray_w;
      tick();
      if (wrap_w === 1'b1) wraps++;
      if (bin_w !== W'(m_w) || gray_w !== ref_gray(m_w) || wrap_w !== e_wrap_w ||
          $countones(gray_w ^ prev) != 1) begin
        bad_seq++;
        if (bad_seq < 5)
          $display("FAIL count_up step %0d: bin=%0d gray=%h wrap=%b, want bin=%0d gray=%h wrap=%b one-bit-step",
                   i, bin_w, gray_w, wrap_w, m_w, ref_gray(m_w), e_wrap_w);
      end
    end
    n_tests++;
    if (bad_seq != 0) n_fail++;
    n_tests++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL count_up_wraps: got %0d wrap pulses, want 1", wraps);
    end
    n_tests++;
    if (bin_s !== 8'hFF || sat_s !== 1'b1 || wrap_s !== 1'b0) begin
      n_fail++;
      $display("FAIL count_up_sat_end: bin=%h sat=%b wrap=%b, want ff 1 0", bin_s, sat_s, wrap_s);
    end
    en = 1'b0;
  endtask

  task automatic test_load_down();
    logic [W-1:0] exp_b [3];
    logic [W-1:0] exp_g [3];
    exp_b[0] = 8'd128; exp_b[1] = 8'd127; exp_b[2] = 8'd126;
    exp_g[0] = 8'hC0;  exp_g[1] = 8'h40;  exp_g[2] = 8'h41;
    load = 1'b1; load_val = 8'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      n_tests++;
      if (bin_w !== exp_b[i] || gray_w !== exp_g[i]) begin
        n_fail++;
        $display("FAIL load_down[%0d]: bin=%0d gray=%h, want %0d %h", i, bin_w, gray_w, exp_b[i], exp_g[i]);
      end
    end
    tick();
    en = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_b [5] = '{254, 255, 255, 255, 255};
    int chg_cnt = 0;
    int wraps = 0;
    load = 1'b1; load_val = 8'hFE; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0; en = 1'b1;
      if (chg_s === 1'b1) chg_cnt++;
      if (wrap_s === 1'b1) wraps++;
      n_tests++;
      if (bin_s !== W'(exp_b[i]) || sat_s !== (exp_b[i] == 255)) begin
        n_fail++;
        $display("FAIL saturate[%0d]: bin=%0d sat=%b, want %0d %b", i, bin_s, sat_s, exp_b[i], exp_b[i] == 255);
      end
    end
    n_tests++;
    if (chg_cnt != 2 || wraps != 0) begin
      n_fail++;
      $display("FAIL saturate_flags: changed pulses=%0d wraps=%0d, want 2 0", chg_cnt, wraps);
    end
    up_dn = 1'b0;
    #1;
    n_tests++;
    if (sat_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_dir: sat=%b at 255 counting down, want 0", sat_s);
    end
    en = 1'b0;
  endtask

  task automatic test_clr_priority();
    load = 1'b1; load_val = 8'd37;
    tick();
    clr = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 8'h55;
    tick();
    n_tests++;
    if (bin_w !== '0 || chg_w !== 1'b1 || wrap_w !== 1'b0 || gray_w !== '0) begin
      n_fail++;
      $display("FAIL clr_priority: bin=%0d gray=%h chg=%b wrap=%b, want 0 0 1 0", bin_w, gray_w, chg_w, wrap_w);
    end
    load = 1'b0; en = 1'b0;
    tick();
    n_tests++;
    if (chg_w !== 1'b0 || bin_w !== '0) begin
      n_fail++;
      $display("FAIL clr_at_zero: bin=%0d chg=%b, want 0 0", bin_w, chg_w);
    end
    clr = 1'b0; load = 1'b1; load_val = 8'hFF;
    tick();
    load_val = 8'h00;
    tick();
    n_tests++;
    if (bin_w !== '0 || chg_w !== 1'b1 || wrap_w !== 1'b0) begin
      n_fail++;
      $display("FAIL load_cross: bin=%0d chg=%b wrap=%b, want 0 1 0", bin_w, chg_w, wrap_w);
    end
    tick();
    n_tests++;
    if (chg_w !== 1'b0) begin
      n_fail++;
      $display("FAIL load_same: chg=%b, want 0", chg_w);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    int exp_b [3] = '{0, 1, 2};
    load = 1'b1; load_val = 8'd100;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bin_w !== '0 || gray_w !== '0 || wrap_w !== 1'b0 || chg_w !== 1'b0 || bin_s !== '0) begin
      n_fail++;
      $display("FAIL async_reset: bin=%0d gray=%h wrap=%b chg=%b bin_s=%0d, want all 0", bin_w, gray_w, wrap_w, chg_w, bin_s);
    end
    m_w = 0; m_s = 0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      n_tests++;
      if (bin_w !== W'(exp_b[i]) || gray_w !== ref_gray(exp_b[i])) begin
        n_fail++;
        $display("FAIL restart[%0d]: bin=%0d gray=%h, want %0d %h", i, bin_w, gray_w, exp_b[i], ref_gray(exp_b[i]));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random_mix();
    int r;
    int bad = 0;
    logic [W-1:0] conv_w, conv_s;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      clr   = (r < 5);
      load  = (r >= 5 && r < 15);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0: load_val = 8'hFF;
        1: load_val = 8'h00;
        default: load_val = W'($urandom);
      endcase
      tick();
      conv_w = W'(gray2bin(gray_word_t'(gray_w), W));
      conv_s = W'(gray2bin(gray_word_t'(gray_s), W));
      if (bin_w !== W'(m_w) || gray_w !== ref_gray(m_w) || wrap_w !== e_wrap_w ||
          chg_w !== e_chg_w || sat_w !== 1'b0 || conv_w !== bin_w ||
          bin_s !== W'(m_s) || gray_s !== ref_gray(m_s) || wrap_s !== 1'b0 ||
          chg_s !== e_chg_s || conv_s !== bin_s ||
          sat_s !== (up_dn ? (m_s == MAXV) : (m_s == 0))) begin
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: w bin=%0d gray=%h wrap=%b chg=%b | s bin=%0d sat=%b chg=%b ; want w %0d %h %b %b | s %0d chg=%b",
                   i, bin_w, gray_w, wrap_w, chg_w, bin_s, sat_s, chg_s,
                   m_w, ref_gray(m_w), e_wrap_w, e_chg_w, m_s, e_chg_s);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_saturate();
    test_clr_priority();
    test_async_reset();
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
